// File: rtl/psum_ofifo.sv
// psum_ofifo: south-edge output collector for the systolic MAC array.
//
// Each array column delivers its psum with its own valid strobe, skewed in
// time across columns. Every column is buffered in its own FIFO, and only
// complete, column-aligned rows are released on a read request.
//
// Ports:
//   clk      - clock, all state on the rising edge
//   reset    - asynchronous active-low reset
//   in       - south psums, lane i = in[psum_bw*(i+1)-1 -: psum_bw]
//   wr       - per-column push strobes, wr[i] pushes lane i
//   rd       - pop one aligned row
//   out      - registered aligned row, updated on the popping edge
//   o_valid  - every column FIFO holds at least one entry
//   o_full   - at least one column FIFO is full
//   o_ready  - ~o_full
//   err      - sticky overflow/underflow flag, cleared only by reset
//
// Build option:
//   OFIFO_RELU_EN - when defined, each lane passes through ReLU at the output
//                   register (negative psums become 0). Stored data is raw.

module psum_ofifo #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   err
);

    localparam int unsigned AW = $clog2(depth);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    // Column storage; not reset, since the pointers define what is valid.
    logic [psum_bw-1:0] mem_q [col][depth];

    // Read pointers of all columns always move together, so one copy suffices.
    logic [AW:0] wptr_q [col];
    logic [AW:0] wptr_d [col];
    logic [AW:0] rptr_q, rptr_d;

    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   err_q, err_d;

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] push_ok;
    logic           pop_en;
    logic           overflow;
    logic           underflow;

    // Per-column status from the pointers.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < col; i++) begin
            empty[i] = (wptr_q[i] == rptr_q);
            full[i]  = (wptr_q[i] == {~rptr_q[AW], rptr_q[AW-1:0]});
        end
    end

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop_en  = rd & o_valid;

    // A pop in the same cycle frees the slot a full column is writing into.
    assign push_ok   = wr & (~full | {col{pop_en}});
    assign overflow  = |(wr & ~push_ok);
    assign underflow = rd & ~o_valid;

    always_comb begin
        rptr_d = pop_en ? rptr_q + PtrOne : rptr_q;
        err_d  = err_q | overflow | underflow;
        for (int i = 0; i < col; i++) begin
            wptr_d[i] = push_ok[i] ? wptr_q[i] + PtrOne : wptr_q[i];
        end
    end

    // Output row: head of every column, optionally rectified.
    always_comb begin
        logic [psum_bw-1:0] head;
        out_d = out_q;
        head  = '0;
        if (pop_en) begin
            for (int i = 0; i < col; i++) begin
                head = mem_q[i][rptr_q[AW-1:0]];
`ifdef OFIFO_RELU_EN
                if (head[psum_bw-1]) begin
                    head = '0;
                end
`endif
                out_d[psum_bw*i +: psum_bw] = head;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q <= '0;
            out_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < col; i++) begin
                wptr_q[i] <= '0;
            end
        end else begin
            rptr_q <= rptr_d;
            out_q  <= out_d;
            err_q  <= err_d;
            for (int i = 0; i < col; i++) begin
                wptr_q[i] <= wptr_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wptr_q[i][AW-1:0]] <= in[psum_bw*i +: psum_bw];
            end
        end
    end

    assign out = out_q;
    assign err = err_q;

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output collector at the south edge of the systolic MAC array.
- Each column's psum arrives at the array's south boundary with its own per-column valid strobe, skewed in time across columns.
- Buffers each column independently in its own FIFO, then releases complete, column-aligned psum rows to the downstream SRAM writer / SFU on a read request.
- Reader-side counterpart of the array's south output interface.

Parameters:
- col, 8, number of array columns (one lane each)
- psum_bw, 16, psum width per column (two's complement)
- depth, 64, entries per column FIFO; power of 2, at least 2

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in  input  psum_bw*col  south psums from the array; lane i = in[psum_bw*(i+1)-1:psum_bw*i]
- wr  input  col  per-column valid strobes from the array; wr[i] pushes lane i
- rd  input  1  pop one aligned row
- out  output  psum_bw*col  registered aligned row; lane i is column i
- o_valid  output  1  every column FIFO is non-empty, so a row is available
- o_full  output  1  at least one column FIFO is full
- o_ready  output  1  equals ~o_full
- err  output  1  sticky flag: overflow or underflow occurred

Behaviour:
- Reset (reset=0, async) clears:
  - all write/read pointers;
  - out=0, err=0;
  - so o_valid=0, o_full=0, o_ready=1.
- Storage: col independent FIFOs, depth entries each.
- Pointers: log2(depth)+1 bits, the MSB being the wrap bit.
  - empty_i when the pointers are fully equal.
  - full_i when the low bits are equal and the MSBs differ.
- Push, column i, when wr[i]=1:
  - Written at wptr_i, wptr_i+1.
  - Accepted if ~full_i, or if a pop is occurring in the same cycle (pop frees the slot).
  - Otherwise dropped, and err<=1.
- Pop: pop_en = rd & o_valid.
  - Every column's rptr advances by 1 together.
  - out <= head entries of all columns.
  - Latency: out is updated on the same edge that samples rd=1, so it is visible from the next cycle.
  - out holds its value when there is no pop.
- rd=1 while o_valid=0: no pointer change, out holds, err<=1 (underflow).
- Alignment:
  - Columns fill at different times because of array skew.
  - o_valid is the AND over all ~empty_i.
  - Partial rows are never emitted.
- Status outputs o_valid, o_full and o_ready are combinational from the pointers; they reflect the state after the previous edge.
- Pointer wrap-around at depth is seamless; the MSB toggles on each wrap.
- Simultaneous push and pop on the same column:
  - Allowed, including when the column is full or empty.
  - When empty with push+pop, o_valid was 0, so the pop does not occur; the push is accepted.
- err is cleared only by reset.
- Arithmetic: no arithmetic in the datapath except the optional feature below; psums pass through bit-exact.
- Reset asserted mid-operation: all buffered data is discarded; outputs return to their reset values asynchronously.

Optional Feature:
- Macro: OFIFO_RELU_EN
- Defined:
  - Each lane is registered through ReLU on pop: a negative psum (MSB=1) is replaced by 0; non-negative values pass unchanged.
  - Stored data is unaffected; ReLU is applied at the output register only.
- Undefined: out is the raw stored psum; no ReLU logic is present.

Test Plan:
- Reset, then skewed fill: pulse wr[i] at cycle t0+i with lane i = 16'h0010+i.
  - o_valid stays 0 until the cycle after wr[7].
  - Then rd=1 gives out = {16'h0017,...,16'h0010}.
  - o_valid then returns to 0; err=0.
- Full: with depth=64, push 64 rows with all wr=8'hFF and no rd.
  - o_full=1, o_ready=0.
  - A 65th push is dropped, err=1.
  - 64 reads then return the first 64 rows in order.
- Simultaneous push and pop at full: during a pop, push row 16'hAAAA on all lanes.
  - Accepted, err stays 0.
  - The row is read back last after draining.
- Wrap-around: 200 interleaved single push/pop cycles (data = index).
  - Output sequence is 0..199 exactly; o_full never 1; err=0.
- Underflow and reset:
  - rd=1 when empty → out unchanged, err=1.
  - Assert reset=0 mid-fill (3 rows buffered) → o_valid=0, err=0, out=0 immediately, without waiting for a clock edge.
- OFIFO_RELU_EN defined: push lanes {16'hFFFF (-1), 16'h7FFF, 16'h8000, 16'h0000, ...}.
  - out = {0, 16'h7FFF, 0, 0, ...}.
  - With the macro undefined, out = the raw input values.
